// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch/load-store memory port arbiter.
// Includes the FSM state codes, port identifiers and fetch byte enables.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [3:0] BE_ALL = 4'b1111;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin picker for the fetch and load/store ports.
// It is purely combinational; the caller holds the last-grant state.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_port
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_port  = PORT_I;
    if (req_i && req_d) begin
      gnt_port = ~last_gnt;
    end else if (req_d) begin
      gnt_port = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch and load/store.
// Each access runs grant, issue, wait and ack; stall freezes the core.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    irdata_q, irdata_d;
  logic [DW-1:0]    drdata_q, drdata_d;
  logic             iack_q, iack_d;
  logic             dack_q, dack_d;

  logic gnt_valid;
  logic gnt_port;

  arb_rr2 u_rr (
    .req_i     (i_req),
    .req_d     (d_req),
    .last_gnt  (last_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_port;
          last_d  = gnt_port;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = ST_ACCESS;
          if (gnt_port == PORT_D) begin
            we_d    = d_we;
            be_d    = d_be;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            be_d    = BE_ALL;
            addr_d  = i_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (owner_q == PORT_I) begin
            irdata_d = mem_rdata;
            iack_d   = 1'b1;
          end else begin
            dack_d = 1'b1;
            if (!we_q) drdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT_I;
      owner_q  <= PORT_I;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = irdata_q;
  assign d_rdata   = drdata_q;
  assign i_ack     = iack_q;
  assign d_ack     = dack_q;

  // Stall drops in the ack cycle so the core advances exactly once.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
